// File: rtl/write_back_if.sv
// Commit bus from execute into write_back: one strobe plus the GPR, CSR
// and next-PC payload that is valid while the strobe is high.
interface write_back_if;
   logic        enabled;
   logic [4:0]  wb_rd_idx;
   logic        wb_rd_we;
   logic [31:0] wb_rd;
   logic [11:0] wb_csr_idx;
   logic        wb_csr_we;
   logic [31:0] wb_csrd;
   logic [31:0] wb_jump_dest;

   modport master (
      output enabled, wb_rd_idx, wb_rd_we, wb_rd,
      output wb_csr_idx, wb_csr_we, wb_csrd, wb_jump_dest
   );

   modport slave (
      input enabled, wb_rd_idx, wb_rd_we, wb_rd,
      input wb_csr_idx, wb_csr_we, wb_csrd, wb_jump_dest
   );
endinterface

// File: rtl/write_back.sv
// Final pipeline stage: commits execute results into the GPR file, the CSR
// file and the PC, serves combinational register/CSR reads with bypass of
// the commit in flight, and keeps the cycle/instret counters.
module write_back #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              rst,
   write_back_if.slave       wb,
   input  logic [4:0]        rs1_idx,
   input  logic [4:0]        rs2_idx,
   output logic [31:0]       rs1_data,
   output logic [31:0]       rs2_data,
   input  logic [11:0]       csr_idx,
   output logic [31:0]       csr_data,
   output logic [31:0]       pc,
   output logic              retired,
   output logic [63:0]       instret
);

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_CYCLE    = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [11:0] CSR_INSTRET  = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH = 12'hC82;

   logic [31:0] gpr_q [32];
   logic [31:0] mstatus_q, mstatus_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mscratch_q, mscratch_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] pc_q, pc_d;
   logic        retired_q, retired_d;
   logic [63:0] instret_q, instret_d;
   logic [63:0] cycle_q, cycle_d;
   logic        gpr_we;
   logic        csr_we;

   // Decode which architectural writes this commit performs
   always_comb begin
      gpr_we = wb.enabled && wb.wb_rd_we && (wb.wb_rd_idx != 5'd0);
      csr_we = 1'b0;
      if (wb.enabled && wb.wb_csr_we) begin
         case (wb.wb_csr_idx)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC: csr_we = 1'b1;
            default:                                        csr_we = 1'b0;
         endcase
      end
   end

   // Next state of PC, counters, retire pulse and writable CSRs
   always_comb begin
      pc_d       = pc_q;
      retired_d  = wb.enabled;
      instret_d  = instret_q;
      cycle_d    = cycle_q + 64'd1;
      mstatus_d  = mstatus_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      if (wb.enabled) begin
         pc_d      = wb.wb_jump_dest;
         instret_d = instret_q + 64'd1;
      end
      if (csr_we) begin
         case (wb.wb_csr_idx)
            CSR_MSTATUS:  mstatus_d  = wb.wb_csrd;
            CSR_MTVEC:    mtvec_d    = wb.wb_csrd;
            CSR_MSCRATCH: mscratch_d = wb.wb_csrd;
            CSR_MEPC:     mepc_d     = wb.wb_csrd;
            default:      ;
         endcase
      end
   end

   // State registers; reset drops any commit presented on the same edge
   always_ff @(posedge clk) begin
      if (rst) begin
         gpr_q      <= '{default: '0};
         mstatus_q  <= '0;
         mtvec_q    <= '0;
         mscratch_q <= '0;
         mepc_q     <= '0;
         pc_q       <= RESET_PC;
         retired_q  <= 1'b0;
         instret_q  <= '0;
         cycle_q    <= '0;
      end else begin
         mstatus_q  <= mstatus_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         pc_q       <= pc_d;
         retired_q  <= retired_d;
         instret_q  <= instret_d;
         cycle_q    <= cycle_d;
         if (gpr_we) begin
            gpr_q[wb.wb_rd_idx] <= wb.wb_rd;
         end
      end
   end

   // GPR read ports: x0 is hardwired zero, in-flight commit is forwarded
   always_comb begin
      rs1_data = '0;
      rs2_data = '0;
      if (rs1_idx != 5'd0) begin
         rs1_data = (gpr_we && (rs1_idx == wb.wb_rd_idx)) ? wb.wb_rd : gpr_q[rs1_idx];
      end
      if (rs2_idx != 5'd0) begin
         rs2_data = (gpr_we && (rs2_idx == wb.wb_rd_idx)) ? wb.wb_rd : gpr_q[rs2_idx];
      end
   end

   // CSR read port: counters show the registered (pre-increment) value,
   // only writable CSRs are forwarded from the commit in flight
   always_comb begin
      case (csr_idx)
         CSR_MSTATUS:  csr_data = mstatus_q;
         CSR_MTVEC:    csr_data = mtvec_q;
         CSR_MSCRATCH: csr_data = mscratch_q;
         CSR_MEPC:     csr_data = mepc_q;
         CSR_CYCLE:    csr_data = cycle_q[31:0];
         CSR_CYCLEH:   csr_data = cycle_q[63:32];
         CSR_INSTRET:  csr_data = instret_q[31:0];
         CSR_INSTRETH: csr_data = instret_q[63:32];
         default:      csr_data = '0;
      endcase
      if (csr_we && (wb.wb_csr_idx == csr_idx)) begin
         csr_data = wb.wb_csrd;
      end
   end

   assign pc      = pc_q;
   assign retired = retired_q;
   assign instret = instret_q;

endmodule

// File: doc/write_back.md
# write_back

Final pipeline stage, directly downstream of `execute`. It commits `execute`'s registered results into architectural state: the 32×32 integer register file, a small CSR file, and the program counter. It also serves the combinational register and CSR read ports that the decode/register-read stage uses to build the `rs1`/`rs2`/`csr` operands for `execute`. It keeps cycle and retired-instruction counters and emits a one-cycle `retired` pulse that the core sequencer uses to start the next fetch.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC value after reset (word address, matching `execute`'s `pc + 1` arithmetic).

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: synchronous reset, active-high.
- `enabled` in 1: commit strobe; all inputs below are valid this cycle.
- `wb_rd_idx` in 5: destination register index (`instr_out.rd`).
- `wb_rd_we` in 1: instruction writes a GPR.
- `wb_rd` in 32: GPR write data (`execute.rd`).
- `wb_csr_idx` in 12: CSR address (`instr_out.imm[11:0]`).
- `wb_csr_we` in 1: instruction writes a CSR (`instr_out.is_csr`).
- `wb_csrd` in 32: CSR write data (`execute.csrd`).
- `wb_jump_dest` in 32: next PC (`execute.jump_dest`, already `pc + 1` when no jump).
- `rs1_idx`, `rs2_idx` in 5 each: read addresses.
- `rs1_data`, `rs2_data` out 32 each: read data.
- `csr_idx` in 12: CSR read address.
- `csr_data` out 32: CSR read data.
- `pc` out 32: architectural PC.
- `retired` out 1: registered pulse, high for one cycle after each commit.
- `instret` out 64: retired-instruction count.

## Operation
- GPR file: x1–x31 are writable. Index 0 reads 0 and ignores writes.
- Commit happens on the clock edge where `enabled=1`:
  - If `wb_rd_we=1` and `wb_rd_idx≠0`: `gpr[wb_rd_idx] <= wb_rd`.
  - If `wb_csr_we=1`: write the CSR addressed by `wb_csr_idx`.
  - `pc <= wb_jump_dest` (always, including not-taken branches).
  - `instret <= instret + 1`.
  - `retired <= 1`.
- When `enabled=0`: no state changes except `cycle` increments and `retired <= 0`.
- Read bypass: if `enabled && wb_rd_we && wb_rd_idx≠0 && rsN_idx==wb_rd_idx`, then `rsN_data = wb_rd`; otherwise the data comes from the array. CSR reads are bypassed the same way when the written address is writable.
- CSR map:
  - 0x300 `mstatus`, 0x305 `mtvec`, 0x340 `mscratch`, 0x341 `mepc`: full 32-bit read/write.
  - 0xC00 `cycle`, 0xC80 `cycleh`, 0xC02 `instret`, 0xC82 `instreth`: read-only. Writes are ignored and never bypassed.
  - Any other address reads 0 and ignores writes.
- `cycle` is 64-bit and increments every non-reset cycle. It wraps at 2^64−1 to 0, and so does `instret`.
- A commit that is also the counter's wrap cycle reads back the pre-increment value that cycle and the wrapped value the next cycle.

## Timing
- Reset (`rst=1` at an edge):
  - `pc=RESET_PC`, `retired=0`, `instret=0`, `cycle=0`.
  - All GPRs and writable CSRs = 0.
  - Reset overrides a simultaneous `enabled`; that commit is dropped.
  - Reset mid-stream discards nothing pending, because there is no internal buffering.
- Commit latency: state is visible one edge after `enabled`. `retired` is asserted in the cycle immediately after the commit edge.
- Read ports are combinational, with zero-cycle bypass of the commit in flight.
- `enabled` may be asserted on back-to-back cycles. Each assertion is a distinct commit and produces its own `retired` pulse, so `retired` can stay high continuously.
- Simultaneous GPR and CSR write (csrrw-type) in the same commit is legal; both update on the same edge.
- `pc` is registered only; there is no combinational path from `wb_jump_dest` to `pc`.

## Test plan
- Reset: hold `rst` 2 cycles with `enabled=1`, `RESET_PC=32'h10` -> `pc=0x10`, `retired=0`, `instret=0`, `rs1_data=0` for every index.
- GPR write/bypass: commit `wb_rd_idx=5`, `wb_rd=0xDEADBEEF` with `rs1_idx=5` in the same cycle -> `rs1_data=0xDEADBEEF` both that cycle and the next. A write to x0 -> `rs2_idx=0` reads 0.
- CSR: commit `wb_csr_idx=0x340`, `wb_csrd=0x1234` plus `wb_rd_idx=7`, `wb_rd=old` -> both updated next cycle. A write to 0xC00 is ignored. 0x7FF reads 0.
- PC/retire: 4 back-to-back commits with `wb_jump_dest` = 1, 2, 40, 41 -> `pc` follows one cycle later, `retired` high 4 consecutive cycles, `instret=4`.
- Counter wrap: force `instret=64'hFFFF_FFFF_FFFF_FFFF`, commit -> `instret=0`, `instreth` reads 0.
- Reset mid-stream: assert `rst` on the same edge as a commit to x3 -> x3=0, `pc=RESET_PC`, no `retired` pulse.
